// File: rtl/conexao_sensor_multi_if.sv
// Host request/response bundle for the multi-channel sensor controller.
// Latency: n/a (wiring only).
// Backpressure: none; the host must hold off requests while busy is high.
interface conexao_sensor_multi_if;
    logic       enable;
    logic [7:0] request_command;
    logic [7:0] request_address;
    logic       dadosPodemSerEnviados;
    logic [7:0] response_command;
    logic [7:0] response_value;
    logic       busy;
    logic       continuous_active;

    // Host side: issues requests, consumes responses.
    modport master (
        output enable, request_command, request_address,
        input  dadosPodemSerEnviados, response_command, response_value,
        input  busy, continuous_active
    );

    // Controller side.
    modport slave (
        input  enable, request_command, request_address,
        output dadosPodemSerEnviados, response_command, response_value,
        output busy, continuous_active
    );
endinterface

// File: rtl/conexao_sensor_multi.sv
// Multi-channel sensor controller: one-shot and continuous acquisition, checksum check, host responses.
// Latency: sensor response 2 cycles after the sampled done; non-sensor response 1 cycle after enable.
// Backpressure: busy high ignores enable; a channel that never answers is released by the timeout.
module conexao_sensor_multi #(
    parameter int NUM_SENSORS    = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int POLL_CYCLES    = 100_000_000
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    conexao_sensor_multi_if.slave      host,
    output logic [NUM_SENSORS-1:0]     o_sensor_start,
    input  logic [NUM_SENSORS-1:0]     i_sensor_done,
    input  logic [NUM_SENSORS-1:0]     i_sensor_error,
    input  logic [40*NUM_SENSORS-1:0]  i_sensor_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_EVAL,
        S_SEND,
        S_CONT
    } state_t;

    localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);

    state_t                 r_state;
    logic [7:0]             r_cmd;
    logic [7:0]             r_addr;
    logic [31:0]            r_tcnt;
    logic [31:0]            r_pcnt;
    logic [39:0]            r_data;
    logic                   r_err;
    logic                   r_tout;
    logic [NUM_SENSORS-1:0] r_start;
    logic                   r_strobe;
    logic [7:0]             r_resp_cmd;
    logic [7:0]             r_resp_val;
    logic                   r_busy;
    logic                   r_cont;
    logic                   r_cont_ret;   // SEND returns to CONT instead of IDLE

    logic [NUM_SENSORS-1:0] w_req_onehot;
    logic [NUM_SENSORS-1:0] w_lat_onehot;
    logic                   w_done_sel;
    logic                   w_err_sel;
    logic [39:0]            w_data_sel;
    logic                   w_addr_ok;
    logic [7:0]             w_sum;
    logic                   w_fail;
    logic                   w_stop_match;

    // Decode requested/latched channel and mux the latched channel's sensor inputs.
    always_comb begin
        w_req_onehot = '0;
        w_lat_onehot = '0;
        w_done_sel   = 1'b0;
        w_err_sel    = 1'b0;
        w_data_sel   = '0;
        for (int n = 0; n < NUM_SENSORS; n++) begin
            if (host.request_address == 8'(n)) begin
                w_req_onehot[n] = 1'b1;
            end
            if (r_addr == 8'(n)) begin
                w_lat_onehot[n] = 1'b1;
                w_done_sel      = i_sensor_done[n];
                w_err_sel       = i_sensor_error[n];
                w_data_sel      = i_sensor_data[40*n +: 40];
            end
        end
    end

    // An out-of-range address decodes to no channel at all.
    assign w_addr_ok = |w_req_onehot;

    // Checksum is the byte sum of the four data fields with carries dropped.
    assign w_sum  = r_data[39:32] + r_data[31:24] + r_data[23:16] + r_data[15:8];
    assign w_fail = r_tout | r_err | (w_sum != r_data[7:0]);

    // Stop only disarms the mode it matches: 0x05 for temperature, 0x06 for humidity.
    assign w_stop_match = ((r_cmd == 8'h03) && (host.request_command == 8'h05)) ||
                          ((r_cmd == 8'h04) && (host.request_command == 8'h06));

    // Main controller FSM with registered outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_cmd      <= '0;
            r_addr     <= '0;
            r_tcnt     <= '0;
            r_pcnt     <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
            r_tout     <= 1'b0;
            r_start    <= '0;
            r_strobe   <= 1'b0;
            r_resp_cmd <= '0;
            r_resp_val <= '0;
            r_busy     <= 1'b0;
            r_cont     <= 1'b0;
            r_cont_ret <= 1'b0;
        end else begin
            r_start  <= '0;
            r_strobe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (host.enable) begin
                        r_busy <= 1'b1;
                        if (!w_addr_ok) begin
                            r_resp_cmd <= 8'h1F;
                            r_resp_val <= 8'hFE;
                            r_strobe   <= 1'b1;
                            r_cont_ret <= 1'b0;
                            r_state    <= S_SEND;
                        end else if ((host.request_command == 8'h05) ||
                                     (host.request_command == 8'h06)) begin
                            r_resp_cmd <= 8'hAA;
                            r_resp_val <= 8'hAA;
                            r_strobe   <= 1'b1;
                            r_cont_ret <= 1'b0;
                            r_state    <= S_SEND;
                        end else if (host.request_command > 8'h06) begin
                            r_resp_cmd <= 8'h45;
                            r_resp_val <= 8'h45;
                            r_strobe   <= 1'b1;
                            r_cont_ret <= 1'b0;
                            r_state    <= S_SEND;
                        end else begin
                            r_cmd   <= host.request_command;
                            r_addr  <= host.request_address;
                            r_start <= w_req_onehot;
                            r_state <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done on the last timeout cycle still counts as a completed read.
                    if (w_done_sel) begin
                        r_data  <= w_data_sel;
                        r_err   <= w_err_sel;
                        r_tout  <= 1'b0;
                        r_state <= S_EVAL;
                    end else if (r_tcnt == TOUT_LAST) begin
                        r_err   <= 1'b0;
                        r_tout  <= 1'b1;
                        r_state <= S_EVAL;
                    end else begin
                        r_tcnt <= r_tcnt + 32'd1;
                    end
                end
                S_EVAL: begin
                    r_strobe   <= 1'b1;
                    r_cont_ret <= (r_cmd == 8'h03) || (r_cmd == 8'h04);
                    r_state    <= S_SEND;
                    if (w_fail) begin
                        r_resp_cmd <= 8'h1F;
                        r_resp_val <= 8'h1F;
                    end else if (r_cmd == 8'h00) begin
                        r_resp_cmd <= 8'h07;
                        r_resp_val <= 8'h07;
                    end else if ((r_cmd == 8'h01) || (r_cmd == 8'h03)) begin
                        r_resp_cmd <= 8'h09;
                        r_resp_val <= r_data[23:16];
                    end else begin
                        r_resp_cmd <= 8'h08;
                        r_resp_val <= r_data[39:32];
                    end
                end
                S_SEND: begin
                    r_busy <= 1'b0;
                    if (r_cont_ret) begin
                        r_cont  <= 1'b1;
                        r_pcnt  <= '0;
                        r_state <= S_CONT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CONT: begin
                    // A host request in the same cycle as the poll tick wins; the poll is skipped.
                    if (host.enable) begin
                        r_busy   <= 1'b1;
                        r_strobe <= 1'b1;
                        r_pcnt   <= '0;
                        r_state  <= S_SEND;
                        if (w_stop_match) begin
                            r_resp_cmd <= 8'h0A;
                            r_resp_val <= 8'h0A;
                            r_cont     <= 1'b0;
                            r_cont_ret <= 1'b0;
                        end else begin
                            r_resp_cmd <= 8'hFF;
                            r_resp_val <= 8'hFF;
                            r_cont_ret <= 1'b1;
                        end
                    end else if (r_pcnt == POLL_LAST) begin
                        r_busy  <= 1'b1;
                        r_start <= w_lat_onehot;
                        r_pcnt  <= '0;
                        r_state <= S_START;
                    end else begin
                        r_pcnt <= r_pcnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_sensor_start             = r_start;
    assign host.dadosPodemSerEnviados = r_strobe;
    assign host.response_command      = r_resp_cmd;
    assign host.response_value        = r_resp_val;
    assign host.busy                  = r_busy;
    assign host.continuous_active     = r_cont;

endmodule

// File: tb/tb_conexao_sensor_multi.sv
// Bench for conexao_sensor_multi: directed scenarios plus randomized one-shot traffic.
// Latency expectations come from the response-timing rules, not the state machine.
// Backpressure: host noise is injected while busy to show it is ignored.
module tb_conexao_sensor_multi;
    localparam int NS = 4;
    localparam int TO = 16;
    localparam int PC = 32;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [NS-1:0]   done;
    logic [NS-1:0]   serr;
    logic [40*NS-1:0] sdata;
    logic [NS-1:0]   sstart;

    int checks = 0;
    int errors = 0;

    conexao_sensor_multi_if bus ();

    conexao_sensor_multi #(
        .NUM_SENSORS   (NS),
        .TIMEOUT_CYCLES(TO),
        .POLL_CYCLES   (PC)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .host          (bus),
        .o_sensor_start(sstart),
        .i_sensor_done (done),
        .i_sensor_error(serr),
        .i_sensor_data (sdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NS-1:0] onehot(input int ch);
        logic [NS-1:0] v;
        v = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

    // Expected sensor-path response from the command and what the channel delivered.
    function automatic logic [15:0] exp_resp(input logic [7:0] cmd, input logic [39:0] d,
                                             input logic err, input logic tout);
        logic [7:0] s;
        s = d[39:32] + d[31:24] + d[23:16] + d[15:8];
        if (tout || err || (s != d[7:0])) return 16'h1F1F;
        case (cmd)
            8'h00:        return 16'h0707;
            8'h01, 8'h03: return {8'h09, d[23:16]};
            default:      return {8'h08, d[39:32]};
        endcase
    endfunction

    // Expected response for requests that never touch a sensor.
    function automatic logic [15:0] exp_imm(input logic [7:0] cmd, input logic [7:0] addr);
        if (int'(addr) >= NS) return 16'h1FFE;
        if ((cmd == 8'h05) || (cmd == 8'h06)) return 16'hAAAA;
        return 16'h4545;
    endfunction

    function automatic logic [39:0] rand_data();
        logic [7:0] h, hf, t, tf, s;
        h  = 8'($urandom);
        hf = 8'($urandom);
        t  = 8'($urandom);
        tf = 8'($urandom);
        s  = h + hf + t + tf;
        if ($urandom_range(0, 3) == 0) s = 8'($urandom);
        return {h, hf, t, tf, s};
    endfunction

    task automatic host_req(input logic [7:0] cmd, input logic [7:0] addr);
        bus.enable          = 1'b1;
        bus.request_command = cmd;
        bus.request_address = addr;
        tick();
        bus.enable = 1'b0;
    endtask

    // Request answered without sensor access; called just before the request cycle.
    task automatic immediate_req(input string tag, input logic [7:0] cmd, input logic [7:0] addr,
                                 input logic [15:0] exp, input logic exp_cont);
        host_req(cmd, addr);
        check({tag, "_strobe"}, bus.dadosPodemSerEnviados, 1'b1);
        check({tag, "_resp"}, {bus.response_command, bus.response_value}, exp);
        check({tag, "_nostart"}, sstart, '0);
        tick();
        check({tag, "_strobe_low"}, bus.dadosPodemSerEnviados, 1'b0);
        check({tag, "_held"}, {bus.response_command, bus.response_value}, exp);
        check({tag, "_busy_low"}, bus.busy, 1'b0);
        check({tag, "_cont"}, bus.continuous_active, exp_cont);
    endtask

    // Runs one acquisition from the cycle sensor_start is visible; d = ticks until done (>TO: never).
    task automatic acquire(input string tag, input int ch, input logic [7:0] cmd, input int d,
                           input logic [39:0] data, input logic err, input bit noise,
                           input logic exp_cont);
        logic [15:0] exp;
        int lat;
        bit seen;
        bit extra;
        exp   = exp_resp(cmd, data, err, d > TO);
        lat   = 0;
        seen  = 0;
        extra = 0;
        sdata[ch*40 +: 40] = data;
        for (int t = 1; t <= 40 && !seen; t++) begin
            tick();
            done = '0;
            serr = '0;
            for (int n = 0; n < NS; n++) begin
                if (n != ch) begin
                    done[n] = 1'($urandom);
                    serr[n] = 1'($urandom);
                    sdata[n*40 +: 40] = {$urandom, 8'($urandom)};
                end
            end
            bus.enable          = noise ? 1'($urandom) : 1'b0;
            bus.request_command = 8'($urandom);
            bus.request_address = 8'($urandom);
            if (sstart !== '0) extra = 1;
            if (bus.dadosPodemSerEnviados === 1'b1) begin
                seen       = 1;
                lat        = t;
                bus.enable = 1'b0;
            end else if (t == d) begin
                done[ch] = 1'b1;
                serr[ch] = err;
            end
        end
        bus.enable = 1'b0;
        done = '0;
        serr = '0;
        check({tag, "_latency"}, lat, (d <= TO) ? d + 2 : TO + 2);
        check({tag, "_resp"}, {bus.response_command, bus.response_value}, exp);
        check({tag, "_start_once"}, extra, 1'b0);
        tick();
        check({tag, "_strobe_low"}, bus.dadosPodemSerEnviados, 1'b0);
        check({tag, "_busy_low"}, bus.busy, 1'b0);
        check({tag, "_cont"}, bus.continuous_active, exp_cont);
    endtask

    // Issues a sensor request and checks the single start pulse.
    task automatic sensor_req(input string tag, input logic [7:0] cmd, input int ch);
        host_req(cmd, 8'(ch));
        check({tag, "_start"}, sstart, onehot(ch));
        check({tag, "_busy"}, bus.busy, 1'b1);
    endtask

    // Waits in continuous mode for the next poll start, counted from CONT entry.
    task automatic wait_poll(input string tag, input int ch);
        int hit;
        hit = 0;
        for (int t = 1; t <= 40 && hit == 0; t++) begin
            tick();
            if (sstart !== '0) hit = t;
        end
        check({tag, "_interval"}, hit, PC);
        check({tag, "_start"}, sstart, onehot(ch));
        check({tag, "_cont"}, bus.continuous_active, 1'b1);
    endtask

    task automatic quiet(input string tag, input int n);
        bit any;
        any = 0;
        for (int t = 0; t < n; t++) begin
            tick();
            if ((sstart !== '0) || (bus.dadosPodemSerEnviados !== 1'b0)) any = 1;
        end
        check({tag, "_quiet"}, any, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, sstart, '0);
        check({tag, "_outs"}, {bus.dadosPodemSerEnviados, bus.response_command,
                               bus.response_value, bus.busy, bus.continuous_active}, '0);
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [39:0] data;
        int          pick;
        int          d;

        bus.enable          = 1'b0;
        bus.request_command = '0;
        bus.request_address = '0;
        done  = '0;
        serr  = '0;
        sdata = '0;

        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        #20;
        @(negedge clk) rst_n = 1'b1;
        tick();
        tick();

        // Temperature read on channel 1, done 10 cycles after start.
        sensor_req("t037", 8'h01, 1);
        acquire("t037", 1, 8'h01, 10, 40'h37_00_19_00_50, 1'b0, 1'b0, 1'b0);

        // Checksum off by one, then correct.
        sensor_req("t038a", 8'h00, 0);
        acquire("t038a", 0, 8'h00, 4, 40'h37_00_19_00_51, 1'b0, 1'b0, 1'b0);
        sensor_req("t038b", 8'h00, 0);
        acquire("t038b", 0, 8'h00, 4, 40'h37_00_19_00_50, 1'b0, 1'b0, 1'b0);

        // Non-sensor requests.
        immediate_req("badaddr", 8'h01, 8'd5, 16'h1FFE, 1'b0);
        immediate_req("stop_idle", 8'h05, 8'd0, 16'hAAAA, 1'b0);
        immediate_req("unknown", 8'h09, 8'd2, 16'h4545, 1'b0);

        // Timeout, and done on the very last timeout cycle.
        sensor_req("tout", 8'h02, 2);
        acquire("tout", 2, 8'h02, TO + 5, 40'h10_00_20_00_30, 1'b0, 1'b0, 1'b0);
        sensor_req("edge", 8'h02, 3);
        acquire("edge", 3, 8'h02, TO, 40'h10_00_20_00_30, 1'b0, 1'b0, 1'b0);
        sensor_req("serr", 8'h01, 2);
        acquire("serr", 2, 8'h01, 3, 40'h10_00_20_00_30, 1'b1, 1'b0, 1'b0);

        // Randomized one-shot traffic with host and neighbour-channel noise.
        for (int i = 0; i < 24; i++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                3:       cmd = 8'h05;
                4:       cmd = 8'h06;
                5:       cmd = 8'($urandom_range(7, 255));
                default: cmd = 8'($urandom_range(0, 2));
            endcase
            addr = 8'($urandom_range(0, 5));
            repeat ($urandom_range(0, 3)) tick();
            if ((int'(addr) >= NS) || (cmd >= 8'h05)) begin
                immediate_req("rnd_imm", cmd, addr, exp_imm(cmd, addr), 1'b0);
            end else begin
                d    = $urandom_range(1, TO + 3);
                data = rand_data();
                sensor_req("rnd", cmd, int'(addr));
                acquire("rnd", int'(addr), cmd, d, data, 1'($urandom_range(0, 7) == 0), 1'b1, 1'b0);
            end
        end

        // Continuous humidity mode on channel 3.
        sensor_req("hum", 8'h04, 3);
        acquire("hum", 3, 8'h04, 5, 40'h40_01_02_03_46, 1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 3; p++) begin
            wait_poll("hum_poll", 3);
            acquire("hum_poll", 3, 8'h04, $urandom_range(1, TO + 2), rand_data(),
                    1'($urandom_range(0, 5) == 0), 1'b0, 1'b1);
        end
        // Mismatched stop exactly on the poll terminal cycle: served, poll skipped.
        repeat (PC - 1) tick();
        immediate_req("hum_collide", 8'h05, 8'd0, 16'hFFFF, 1'b1);
        wait_poll("hum_after", 3);
        acquire("hum_after", 3, 8'h04, 2, 40'h22_00_11_00_33, 1'b0, 1'b0, 1'b1);
        repeat (7) tick();
        immediate_req("hum_stop", 8'h06, 8'd0, 16'h0A0A, 1'b0);
        quiet("hum_disarmed", 40);

        // Continuous temperature mode on channel 0.
        sensor_req("temp", 8'h03, 0);
        acquire("temp", 0, 8'h03, 1, 40'h01_02_2A_04_31, 1'b0, 1'b0, 1'b1);
        repeat (5) tick();
        immediate_req("temp_wrong", 8'h06, 8'd0, 16'hFFFF, 1'b1);
        wait_poll("temp_poll", 0);
        acquire("temp_poll", 0, 8'h03, 6, 40'h01_02_2B_04_32, 1'b0, 1'b0, 1'b1);
        immediate_req("temp_stop", 8'h05, 8'd0, 16'h0A0A, 1'b0);

        // Reset during WAIT, then a late done.
        sensor_req("rst_wait", 8'h02, 2);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_wait_async");
        @(negedge clk) rst_n = 1'b1;
        tick();
        sdata[2*40 +: 40] = 40'h10_00_20_00_30;
        done[2] = 1'b1;
        tick();
        done = '0;
        quiet("rst_wait_late", 6);
        check_all_zero("rst_wait_after");

        // Reset while armed in continuous mode.
        sensor_req("rst_cont", 8'h04, 1);
        acquire("rst_cont", 1, 8'h04, 3, 40'h05_05_05_05_14, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_cont_async");
        @(negedge clk) rst_n = 1'b1;
        quiet("rst_cont_nopoll", 40);
        check_all_zero("rst_cont_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conexao_sensor_multi.md
CONEXAO_SENSOR_MULTI -- requirements
Module: conexao_sensor_multi

Interface
REQ-001 Parameter NUM_SENSORS, default 4, number of sensor channels (1..32); channel n serves request_address n.
REQ-002 Parameter TIMEOUT_CYCLES, default 50_000_000, max clocks to wait for sensor_done after sensor_start.
REQ-003 Parameter POLL_CYCLES, default 100_000_000, clocks between continuous-mode acquisitions.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  system clock, all logic on rising edge.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 enable  in  1  one-cycle request strobe; command/address sampled when high.
REQ-008 request_command  in  8  host command code.
REQ-009 request_address  in  8  target channel index.
REQ-010 sensor_start  out  NUM_SENSORS  one-hot, one-cycle acquisition start per channel.
REQ-011 sensor_done  in  NUM_SENSORS  per-channel acquisition-complete pulse.
REQ-012 sensor_error  in  NUM_SENSORS  per-channel reader error, valid with sensor_done.
REQ-013 sensor_data  in  40*NUM_SENSORS  channel n at [40n+39:40n]: hum_int[39:32], hum_frac[31:24], temp_int[23:16], temp_frac[15:8], checksum[7:0].
REQ-014 dadosPodemSerEnviados  out  1  one-cycle response strobe.
REQ-015 response_command  out  8  response code, held until next strobe.
REQ-016 response_value  out  8  response data, held until next strobe.
REQ-017 busy  out  1  high while a request or poll is in progress; enable ignored while high.
REQ-018 continuous_active  out  1  high while continuous sensing is armed.

Function
REQ-019 FSM states SHALL be IDLE, START, WAIT, EVAL, SEND, CONT; busy=1 in START/WAIT/EVAL/SEND.
REQ-020 IDLE+enable: address >= NUM_SENSORS -> response 0x1F/0xFE; command 0x05/0x06 -> 0xAA/0xAA; command > 0x06 -> 0x45/0x45; all via SEND, no sensor access.
REQ-021 IDLE+enable, command 0x00..0x04, valid address: latch command/address, go START; sensor_start[address] high exactly one cycle, the cycle after enable sampled.
REQ-022 WAIT: only sensor_done[address] observed; other channels ignored; timeout counter starts 0, increments per cycle.
REQ-023 Done sampled -> capture data/error, go EVAL; counter reaching TIMEOUT_CYCLES-1 without done -> EVAL flagged failed; done and timeout same cycle -> done wins.
REQ-024 EVAL failure = timeout OR sensor_error OR (hum_int+hum_frac+temp_int+temp_frac) mod 256 != checksum.
REQ-025 EVAL responses: 0x00 -> ok 0x07/0x07, fail 0x1F/0x1F; 0x01/0x03 -> ok 0x09/temp_int; 0x02/0x04 -> ok 0x08/hum_int; fail always 0x1F/0x1F.
REQ-026 Sensor path latency: dadosPodemSerEnviados high exactly 2 cycles after sensor_done sampled; non-sensor responses 1 cycle after enable sampled.
REQ-027 Command 0x03/0x04 SHALL arm continuous mode (temp/hum) after its first response; SEND then goes to CONT, not IDLE.
REQ-028 CONT: poll counter 0..POLL_CYCLES-1; on terminal count, START same address and command, counter reset to 0.
REQ-029 CONT+enable: 0x05 in temp mode or 0x06 in hum mode -> disarm, response 0x0A/0x0A, return IDLE.
REQ-030 CONT+enable, any other command (incl. mismatched stop) -> response 0xFF/0xFF, stay armed, poll counter reset to 0.
REQ-031 Enable and poll terminal count same cycle in CONT: request served, poll skipped.
REQ-032 Poll failures SHALL report 0x1F/0x1F and remain armed.
REQ-033 Checksum arithmetic: 8-bit modulo-256 sum, carries discarded.
REQ-034 Response outputs SHALL change only on the edge raising dadosPodemSerEnviados.

Reset
REQ-035 reset low: state IDLE, all outputs 0 (sensor_start, dadosPodemSerEnviados, response_command, response_value, busy, continuous_active), counters and latched fields 0, immediately without clock.
REQ-036 Reset mid-acquisition or in CONT SHALL abort with no response and disarm continuous mode; late sensor_done after release ignored in IDLE.

Verification
REQ-037 addr 1, cmd 0x01, ch1 data 0x37_00_19_00_50, done 10 cycles later -> sensor_start=0b0010 one cycle, response 0x09/0x19 two cycles after done.
REQ-038 addr 0, cmd 0x00, checksum byte 0x51 (sum 0x50) -> response 0x1F/0x1F; same with checksum 0x50 -> 0x07/0x07.
REQ-039 addr 5 with NUM_SENSORS=4 -> 0x1F/0xFE next cycle, no sensor_start; cmd 0x05 in IDLE -> 0xAA/0xAA; cmd 0x09 -> 0x45/0x45.
REQ-040 TIMEOUT_CYCLES=16, cmd 0x02, no done -> 0x1F/0x1F after 16 WAIT cycles, busy low afterwards.
REQ-041 POLL_CYCLES=32, cmd 0x04 -> periodic 0x08/hum_int every poll; cmd 0x05 -> 0xFF/0xFF, still armed; cmd 0x06 -> 0x0A/0x0A, continuous_active=0.
REQ-042 reset asserted during WAIT then done pulsed -> all outputs 0, no response strobe.
